wb_gateway_arb: RTL and testbench

WB_GATEWAY_ARB -- requirements
Module: wb_gateway_arb

---
 rtl/wb_gateway_arb_if.sv | 33 +++
 rtl/wb_gateway_arb.sv | 178 +++++++++++++++++
 tb/tb_wb_gateway_arb.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_gateway_arb_if.sv
// ---------------------------------------------------------------------------
// wb_gateway_arb_if
// Wishbone classic bus bundle used between the gateway arbiter (master side)
// and a single Wishbone slave.
//   wb_cyc_o / wb_stb_o / wb_we_o : cycle, strobe and write-enable (master out)
//   wb_adr_o / wb_dat_o / wb_sel_o: address, write data, byte selects (master out)
//   wb_dat_i                      : read data (slave out)
//   wb_ack_i / wb_err_i           : termination handshakes (slave out)
// ---------------------------------------------------------------------------
interface wb_gateway_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  wb_cyc_o;
  logic                  wb_stb_o;
  logic                  wb_we_o;
  logic [ADDR_W-1:0]     wb_adr_o;
  logic [DATA_W-1:0]     wb_dat_o;
  logic [DATA_W/8-1:0]   wb_sel_o;
  logic [DATA_W-1:0]     wb_dat_i;
  logic                  wb_ack_i;
  logic                  wb_err_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/wb_gateway_arb.sv
// ---------------------------------------------------------------------------
// wb_gateway_arb
// Round-robin gateway from NUM_CH requester channels onto one Wishbone master
// port. One transfer is outstanding at a time (IDLE -> BUS -> RESP).
// While config_done is low (boot mode) only channel 0 may be granted and the
// round-robin pointer is frozen.
//
// Ports:
//   clk, rstn           : clock (rising edge) and asynchronous active-low reset
//   config_done         : 0 = boot mode
//   req_valid/req_ready : per-channel request handshake (ready is one-hot/zero)
//   req_we/addr/wdata   : per-channel request payload, channel i at slice i
//   resp_valid          : one-cycle per-channel completion pulse
//   resp_rdata/resp_err : shared completion payload, valid with resp_valid
//   wb                  : Wishbone master modport (wb_gateway_arb_if.master)
//
// Optional feature: define WB_GW_TIMEOUT_EN to abort a BUS phase that sees no
// ack/err within TIMEOUT_CYC cycles (completes with resp_err=1, rdata=0).
// ---------------------------------------------------------------------------
module wb_gateway_arb #(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       config_done,
  input  logic [NUM_CH-1:0]          req_valid,
  output logic [NUM_CH-1:0]          req_ready,
  input  logic [NUM_CH-1:0]          req_we,
  input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
  input  logic [NUM_CH*DATA_W-1:0]   req_wdata,
  output logic [NUM_CH-1:0]          resp_valid,
  output logic [DATA_W-1:0]          resp_rdata,
  output logic                       resp_err,
  wb_gateway_arb_if.master           wb
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [NUM_CH-1:0] CH0_MASK = NUM_CH'(1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  if (NUM_CH < 2 || NUM_CH > 8) begin : g_bad_num_ch
    $error("wb_gateway_arb: NUM_CH must be 2..8");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("wb_gateway_arb: TIMEOUT_CYC must be 1..65535");
  end

  logic [1:0]        state_q,  state_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]   gnt_q,    gnt_d;
  logic              we_q,     we_d;
  logic [ADDR_W-1:0] adr_q,    adr_d;
  logic [DATA_W-1:0] dat_q,    dat_d;
  logic [DATA_W-1:0] rdata_q,  rdata_d;
  logic              err_q,    err_d;

  logic [NUM_CH-1:0] eligible;
  logic              found;
  logic [CH_W-1:0]   win;
  logic              timeout;

  // Round-robin search: walk downwards so the channel closest to rr_ptr
  // (smallest offset) is the last one written and therefore wins.
  always_comb begin
    eligible = config_done ? req_valid : (req_valid & CH0_MASK);
    found    = 1'b0;
    win      = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (eligible[(int'(rr_ptr_q) + k) % NUM_CH]) begin
        found = 1'b1;
        win   = CH_W'((int'(rr_ptr_q) + k) % NUM_CH);
      end
    end
  end

  // Ready is gated by rstn so it is low for the whole time reset is held.
  always_comb begin
    req_ready = '0;
    if (rstn && state_q == IDLE && found) req_ready[win] = 1'b1;
  end

`ifdef WB_GW_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;

  assign timeout = (state_q == BUS) && (cnt_q == 16'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = '0;
    if (state_q == BUS) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    we_d     = we_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUS;
          gnt_d   = win;
          we_d    = req_we[win];
          adr_d   = req_addr[win*ADDR_W +: ADDR_W];
          dat_d   = req_wdata[win*DATA_W +: DATA_W];
          if (config_done)
            rr_ptr_d = (win == CH_W'(NUM_CH - 1)) ? '0 : win + 1'b1;
        end
      end
      BUS: begin
        if (wb.wb_ack_i || wb.wb_err_i || timeout) begin
          state_d = RESP;
          // err beats ack; a late ack coinciding with the timeout still wins.
          err_d   = wb.wb_err_i || (timeout && !wb.wb_ack_i);
          rdata_d = (wb.wb_ack_i && !wb.wb_err_i && !we_q) ? wb.wb_dat_i : '0;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Bus outputs decode straight from registered state, so reset releases
  // the bus the moment rstn falls.
  assign wb.wb_cyc_o = (state_q == BUS);
  assign wb.wb_stb_o = (state_q == BUS);
  assign wb.wb_we_o  = we_q;
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_sel_o = (state_q == BUS) ? '1 : '0;

  always_comb begin
    resp_valid = '0;
    if (state_q == RESP) resp_valid[gnt_q] = 1'b1;
  end

  assign resp_rdata = (state_q == RESP) ? rdata_q : '0;
  assign resp_err   = (state_q == RESP) && err_q;

endmodule

// File: tb/tb_wb_gateway_arb.sv
module tb_wb_gateway_arb;
  localparam int NUM_CH      = 2;
  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int TIMEOUT_CYC = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        config_done = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [1:0]  req_we = '0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [1:0]  resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  wb_gateway_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wb_bus ();

  wb_gateway_arb #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rstn(rstn), .config_done(config_done),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .wb(wb_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cfg;
    logic [1:0]  valid;
    logic [1:0]  we;
    logic [31:0] a0, a1, d0, d1;
    int          dly;
    logic        ack, err;
    logic [31:0] slv;
    int          exp_ch;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    int          ch;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t sb[$];
  resp_t mon_e;
  vec_t  vt[10];
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Completion monitor: every resp_valid cycle must match the oldest accept.
  always @(negedge clk) begin
    if (resp_valid != 2'b00) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL resp_unexpected: resp_valid=%b with nothing outstanding", resp_valid);
      end else begin
        mon_e = sb.pop_front();
        check("resp_valid", 64'(resp_valid), 64'(2'b01 << mon_e.ch));
        check("resp_rdata", 64'(resp_rdata), 64'(mon_e.rdata));
        check("resp_err",   64'(resp_err),   64'(mon_e.err));
      end
    end
  end

  task automatic wait_accept(output int g, output bit ok);
    ok = 1'b0;
    g  = -1;
    for (int n = 0; n < 40; n++) begin
      #1;
      if ((req_valid & req_ready) != 2'b00) begin
        ok = 1'b1;
        g  = req_ready[1] ? 1 : 0;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: no accept in 40 cycles, req_valid=%b", req_valid);
    end
  endtask

  // Called on the first BUS-cycle negedge; drives ack/err dly cycles later
  // and returns on the RESP-cycle negedge.
  task automatic slave_resp(input int dly, input logic ack, input logic err, input logic [31:0] d);
    for (int n = 0; n < dly; n++) begin
      @(negedge clk);
      check("cyc_hold", 64'(wb_bus.wb_cyc_o), 64'd1);
    end
    wb_bus.wb_ack_i = ack;
    wb_bus.wb_err_i = err;
    wb_bus.wb_dat_i = d;
    @(negedge clk);
    wb_bus.wb_ack_i = 1'b0;
    wb_bus.wb_err_i = 1'b0;
    wb_bus.wb_dat_i = '0;
  endtask

  task automatic run_vec(input vec_t v, input int i);
    int    g;
    bit    ok;
    resp_t e;
    config_done = v.cfg;
    req_we      = v.we;
    req_addr    = {v.a1, v.a0};
    req_wdata   = {v.d1, v.d0};
    req_valid   = v.valid;
    wait_accept(g, ok);
    if (!ok) begin
      req_valid = '0;
      return;
    end
    check($sformatf("v%0d_grant", i), 64'(g), 64'(v.exp_ch));
    e.ch = v.exp_ch; e.rdata = v.exp_rdata; e.err = v.exp_err;
    sb.push_back(e);
    @(negedge clk);
    req_valid = '0;
    check($sformatf("v%0d_cyc", i), 64'(wb_bus.wb_cyc_o), 64'd1);
    check($sformatf("v%0d_stb", i), 64'(wb_bus.wb_stb_o), 64'd1);
    check($sformatf("v%0d_sel", i), 64'(wb_bus.wb_sel_o), 64'hF);
    check($sformatf("v%0d_adr", i), 64'(wb_bus.wb_adr_o), 64'(v.exp_ch ? v.a1 : v.a0));
    check($sformatf("v%0d_we", i),  64'(wb_bus.wb_we_o),  64'(v.we[v.exp_ch]));
    if (v.we[v.exp_ch])
      check($sformatf("v%0d_dat", i), 64'(wb_bus.wb_dat_o), 64'(v.exp_ch ? v.d1 : v.d0));
    slave_resp(v.dly, v.ack, v.err, v.slv);
    check($sformatf("v%0d_cyc_drop", i), 64'(wb_bus.wb_cyc_o), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int    g;
    bit    ok;
    int    n;
    resp_t e;

    //        cfg  valid  we     a0          a1          d0            d1            dly ack err slv           ch rdata         err
    vt[0] = '{1'b0, 2'b11, 2'b01, 32'h100,    32'h200,    32'hA0A0_0001, 32'hB0B0_0001, 0, 1'b1, 1'b0, 32'hFFFF_FFFF, 0, 32'h0,         1'b0};
    vt[1] = '{1'b0, 2'b11, 2'b00, 32'h104,    32'h204,    32'hA0A0_0002, 32'hB0B0_0002, 1, 1'b1, 1'b0, 32'h1111_1111, 0, 32'h1111_1111, 1'b0};
    vt[2] = '{1'b1, 2'b11, 2'b00, 32'h108,    32'h208,    32'hA0A0_0003, 32'hB0B0_0003, 0, 1'b1, 1'b0, 32'h2222_2222, 0, 32'h2222_2222, 1'b0};
    vt[3] = '{1'b1, 2'b11, 2'b10, 32'h10C,    32'h20C,    32'hA0A0_0004, 32'hB0B0_0004, 0, 1'b1, 1'b0, 32'h3333_3333, 1, 32'h0,         1'b0};
    vt[4] = '{1'b1, 2'b10, 2'b00, 32'h0,      32'h10,     32'h0,         32'h0,         2, 1'b1, 1'b0, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 1'b0};
    vt[5] = '{1'b1, 2'b01, 2'b00, 32'h40,     32'h44,     32'h0,         32'h0,         0, 1'b1, 1'b1, 32'hCAFE_F00D, 0, 32'h0,         1'b1};
    vt[6] = '{1'b1, 2'b01, 2'b01, 32'h48,     32'h4C,     32'hA0A0_0007, 32'h0,         1, 1'b0, 1'b1, 32'h1234_5678, 0, 32'h0,         1'b1};
    vt[7] = '{1'b1, 2'b11, 2'b11, 32'h50,     32'h54,     32'hA0A0_0008, 32'hB0B0_0008, 0, 1'b1, 1'b0, 32'h0000_0055, 1, 32'h0,         1'b0};
    vt[8] = '{1'b1, 2'b10, 2'b00, 32'h58,     32'h5C,     32'h0,         32'h0,         1, 1'b1, 1'b0, 32'h5A5A_A5A5, 1, 32'h5A5A_A5A5, 1'b0};
    vt[9] = '{1'b1, 2'b11, 2'b00, 32'h60,     32'h64,     32'h0,         32'h0,         3, 1'b1, 1'b0, 32'h0BAD_F00D, 0, 32'h0BAD_F00D, 1'b0};

    wb_bus.wb_ack_i = 1'b0;
    wb_bus.wb_err_i = 1'b0;
    wb_bus.wb_dat_i = '0;

    // Reset state with requests pending
    rstn = 1'b0; config_done = 1'b1; req_valid = 2'b11;
    repeat (3) @(negedge clk);
    check("rst_ready",  64'(req_ready),         64'd0);
    check("rst_cyc",    64'(wb_bus.wb_cyc_o),   64'd0);
    check("rst_stb",    64'(wb_bus.wb_stb_o),   64'd0);
    check("rst_we",     64'(wb_bus.wb_we_o),    64'd0);
    check("rst_adr",    64'(wb_bus.wb_adr_o),   64'd0);
    check("rst_sel",    64'(wb_bus.wb_sel_o),   64'd0);
    check("rst_rvalid", 64'(resp_valid),        64'd0);
    check("rst_rdata",  64'(resp_rdata),        64'd0);
    check("rst_rerr",   64'(resp_err),          64'd0);
    req_valid = '0;
    rstn = 1'b1;
    @(negedge clk);

    // Table vectors: boot mode, round robin, read/write, ack+err, err only
    for (int i = 0; i < 10; i++) run_vec(vt[i], i);

    // Request withdrawn before it could be accepted (ch1 masked in boot mode)
    config_done = 1'b0; req_valid = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("wd_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    req_valid = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("wd_cyc", 64'(wb_bus.wb_cyc_o), 64'd0);
    end

    // config_done falls mid-transfer: transfer completes, masking next time
    config_done = 1'b1; req_we = 2'b00; req_valid = 2'b11;
    wait_accept(g, ok);
    check("cdf_grant1", 64'(g), 64'd1);
    if (ok) begin
      e.ch = 1; e.rdata = 32'h2626_2626; e.err = 1'b0; sb.push_back(e);
      @(negedge clk);
      req_valid = '0; config_done = 1'b0;
      slave_resp(1, 1'b1, 1'b0, 32'h2626_2626);
      @(negedge clk);
    end
    req_valid = 2'b11; req_we = 2'b11;
    wait_accept(g, ok);
    check("cdf_grant0", 64'(g), 64'd0);
    if (ok) begin
      e.ch = 0; e.rdata = 32'h0; e.err = 1'b0; sb.push_back(e);
      @(negedge clk);
      req_valid = '0;
      slave_resp(0, 1'b1, 1'b0, 32'h9999_9999);
      @(negedge clk);
    end

    // Reset asserted during BUS: bus drops at once, no completion afterwards
    config_done = 1'b1; req_we = 2'b00; req_valid = 2'b01;
    wait_accept(g, ok);
    @(negedge clk);
    req_valid = '0;
    check("rb_cyc_before", 64'(wb_bus.wb_cyc_o), 64'd1);
    #2 rstn = 1'b0;
    #1;
    check("rb_cyc_async", 64'(wb_bus.wb_cyc_o), 64'd0);
    check("rb_stb_async", 64'(wb_bus.wb_stb_o), 64'd0);
    check("rb_adr_async", 64'(wb_bus.wb_adr_o), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rb_no_resp", 64'(resp_valid), 64'd0);
    end

    // Continuous requests, ack one cycle later: grants alternate 0,1,0,1
    config_done = 1'b1; req_we = 2'b00; req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        #1;
        check($sformatf("alt%0d_ready_now", k), 64'(req_ready), 64'(2'b01 << (k % 2)));
      end
      wait_accept(g, ok);
      if (!ok) break;
      check($sformatf("alt%0d_grant", k), 64'(g), 64'(k % 2));
      e.ch = k % 2; e.rdata = 32'hA000 + 32'(k); e.err = 1'b0; sb.push_back(e);
      @(negedge clk);
      slave_resp(0, 1'b1, 1'b0, 32'hA000 + 32'(k));
      @(negedge clk);
    end
    req_valid = '0;
    @(negedge clk);

    // Silent slave
    req_valid = 2'b01;
    wait_accept(g, ok);
    if (ok) begin
`ifdef WB_GW_TIMEOUT_EN
      e.ch = 0; e.rdata = 32'h0; e.err = 1'b1; sb.push_back(e);
      @(negedge clk);
      req_valid = '0;
      n = 0;
      while (wb_bus.wb_cyc_o && n < 200) begin
        n++;
        @(negedge clk);
      end
      check("to_bus_cycles", 64'(n), 64'(TIMEOUT_CYC));
`else
      e.ch = 0; e.rdata = 32'h0000_0077; e.err = 1'b0; sb.push_back(e);
      @(negedge clk);
      req_valid = '0;
      n = 0;
      for (int i = 0; i < 100; i++) begin
        if (wb_bus.wb_cyc_o) n++;
        if (i < 99) @(negedge clk);
      end
      check("noto_cyc_held", 64'(n), 64'd100);
      slave_resp(0, 1'b1, 1'b0, 32'h0000_0077);
`endif
    end
    repeat (3) @(negedge clk);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
